mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 162 ++++++++++++++++
 tb/tb_mc_control.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle processor control FSM
// Moore-style decode of the current state; pc_en/ir_write/illegal_op also see mem_ready, zero and opcode.
module mc_control #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BEQEX  = 4'd8,
    ADDIEX = 4'd9,
    JEX    = 4'd10,
    IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t cur, nxt;
  logic   ready;

  assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    pc_src     = 2'd0;
    illegal_op = 1'b0;

    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        pc_en     = ready;
        ir_write  = ready;
        if (ready) nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RT:        nxt = REXEC;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default: begin
            nxt        = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        nxt       = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (ready) nxt = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (ready) nxt = FETCH;
      end
      REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        nxt       = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nxt       = FETCH;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_src    = 2'd1;
        pc_en     = zero;
        nxt       = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        nxt       = IWB;
      end
      IWB: begin
        reg_write = 1'b1;
        nxt       = FETCH;
      end
      JEX: begin
        pc_en  = 1'b1;
        pc_src = 2'd2;
        nxt    = FETCH;
      end
      default: nxt = FETCH;
    endcase

    // Reset must suppress every write strobe even though FETCH would otherwise follow mem_ready.
    if (!rst_n) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - table-driven check of mc_control plus reset and no-wait corner cases
module tb_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_ready0;

  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  logic       pc_en1, iord1, mem_read1, mem_write1, ir_write1, reg_dst1, mem_to_reg1, reg_write1, alu_src_a1, illegal_op1;
  logic [1:0] alu_src_b1, alu_op1, pc_src1;
  logic [3:0] state1;

  logic [15:0] obs;

  int checks;
  int errors;

  mc_control #(.MEM_WAIT_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .state(state), .illegal_op(illegal_op)
  );

  mc_control #(.MEM_WAIT_EN(0)) u_nowait (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready0),
    .pc_en(pc_en1), .iord(iord1), .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
    .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .reg_write(reg_write1), .alu_src_a(alu_src_a1),
    .alu_src_b(alu_src_b1), .alu_op(alu_op1), .pc_src(pc_src1), .state(state1), .illegal_op(illegal_op1)
  );

  // {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op}
  assign obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  localparam logic [15:0] F_R   = 16'b1_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [15:0] F_NR  = 16'b0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] DEC   = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [15:0] DEC_I = 16'b0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [15:0] MA    = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] MRD   = 16'b0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] MWB   = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [15:0] MWR   = 16'b0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] REX   = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [15:0] RWB_O = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [15:0] BEQ1  = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] BEQ0  = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] IWB_O = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [15:0] JEX_O = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] out;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [15:0] out);
    vec_t v;
    v.rst_n = r; v.op = op; v.zero = z; v.rdy = rdy; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s idx %0d got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    opcode     = LW;
    zero       = 1'b0;
    mem_ready  = 1'b1;
    mem_ready0 = 1'b0;

    add(0, LW, 0, 1, 0, F_NR);
    add(1, LW, 0, 0, 0, F_NR);
    add(1, LW, 0, 1, 0, F_R);
    add(1, LW, 0, 1, 1, DEC);
    add(1, LW, 0, 1, 2, MA);
    add(1, LW, 0, 1, 3, MRD);
    add(1, LW, 0, 1, 4, MWB);
    add(1, SW, 0, 1, 0, F_R);
    add(1, SW, 0, 1, 1, DEC);
    add(1, SW, 0, 1, 2, MA);
    add(1, SW, 0, 0, 5, MWR);
    add(1, SW, 0, 0, 5, MWR);
    add(1, SW, 0, 0, 5, MWR);
    add(1, SW, 0, 1, 5, MWR);
    add(1, RT, 0, 1, 0, F_R);
    add(1, RT, 0, 1, 1, DEC);
    add(1, RT, 0, 1, 6, REX);
    add(1, RT, 0, 1, 7, RWB_O);
    add(1, ADDI, 0, 1, 0, F_R);
    add(1, ADDI, 0, 1, 1, DEC);
    add(1, ADDI, 0, 1, 9, MA);
    add(1, ADDI, 0, 1, 11, IWB_O);
    add(1, BEQ, 1, 1, 0, F_R);
    add(1, BEQ, 1, 1, 1, DEC);
    add(1, BEQ, 1, 1, 8, BEQ1);
    add(1, BEQ, 0, 1, 0, F_R);
    add(1, BEQ, 0, 1, 1, DEC);
    add(1, BEQ, 0, 1, 8, BEQ0);
    add(1, JMP, 0, 1, 0, F_R);
    add(1, JMP, 0, 1, 1, DEC);
    add(1, JMP, 0, 1, 10, JEX_O);
    add(1, BAD, 0, 1, 0, F_R);
    add(1, BAD, 0, 1, 1, DEC_I);
    add(1, LW, 0, 0, 0, F_NR);
    add(1, LW, 0, 1, 0, F_R);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = vecs[i].rst_n;
      opcode    = vecs[i].op;
      zero      = vecs[i].zero;
      mem_ready = vecs[i].rdy;
      #3;
      check("state", i, {28'd0, state}, {28'd0, vecs[i].st});
      check("outputs", i, {16'd0, obs}, {16'd0, vecs[i].out});
      check("rd_wr_excl", i, {31'd0, mem_read & mem_write}, 32'd0);
      step();
    end

    // lw again into MEMRD, then assert reset asynchronously in the middle of the cycle
    opcode    = LW;
    mem_ready = 1'b1;
    #3;
    check("pre_rst_decode", 0, {28'd0, state}, 32'd1);
    step();
    step();
    #1;
    check("pre_rst_memrd", 0, {28'd0, state}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_async_state", 0, {28'd0, state}, 32'd0);
    check("rst_async_we", 0, {28'd0, pc_en, ir_write, mem_write, reg_write}, 32'd0);
    check("rst_async_ill", 0, {31'd0, illegal_op}, 32'd0);
    step();
    #2;
    check("rst_held_state", 1, {28'd0, state}, 32'd0);
    check("rst_held_we", 1, {28'd0, pc_en, ir_write, mem_write, reg_write}, 32'd0);
    step();
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    #3;
    check("post_rst_wait", 0, {16'd0, obs}, {16'd0, F_NR});
    step();
    check("post_rst_wait_state", 1, {28'd0, state}, 32'd0);
    mem_ready = 1'b1;
    #3;
    check("post_rst_fetch", 1, {16'd0, obs}, {16'd0, F_R});
    step();
    check("post_rst_decode", 0, {28'd0, state}, 32'd1);

    // no-wait instance: FETCH advances with mem_ready tied low
    rst_n = 1'b0;
    #1;
    check("nowait_rst_state", 0, {28'd0, state1}, 32'd0);
    check("nowait_rst_irw", 0, {31'd0, ir_write1}, 32'd0);
    step();
    rst_n = 1'b1;
    #3;
    check("nowait_fetch_irw", 0, {31'd0, ir_write1}, 32'd1);
    check("nowait_fetch_pcen", 0, {31'd0, pc_en1}, 32'd1);
    step();
    check("nowait_decode", 0, {28'd0, state1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
